div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//  EX-stage RV32M divide controller, directly upstream of the iterative divider core.
//  Accepts DIV/DIVU/REM/REMU from EX, stalls the pipeline, issues unsigned magnitudes to the
//  core, applies RISC-V sign, divide-by-zero and overflow rules, returns one 32-bit result
//  to writeback. Handles pipeline flush mid-divide.
// PARAMETERS
//  FAST_SPECIAL  1  1: div-by-zero/overflow resolved locally, core not started; 0: via core
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   async active-low reset
//  ex_valid_i    in   1   divide instruction present in EX
//  ex_op_i       in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//  ex_rs1_i      in   32  dividend
//  ex_rs2_i      in   32  divisor
//  ex_rd_i       in   5   destination register
//  flush_i       in   1   kill instruction in EX
//  stall_o       out  1   hold EX and upstream (combinational)
//  wb_valid_o    out  1   one-cycle result pulse
//  wb_rd_o       out  5   destination of result
//  wb_data_o     out  32  quotient or remainder
//  div_op1_o     out  32  |dividend| to core
//  div_op2_o     out  32  |divisor| to core
//  div_start_o   out  1   core start, level, held until core ready seen
//  div_annul_o   out  1   core abort, one-cycle pulse
//  div_signed_o  out  1   tied 0; signs handled here
//  div_result_i  in   64  core result: [63:32] remainder, [31:0] quotient
//  div_ready_i   in   1   core result valid, level, until start drops
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, captured operands/rd/op cleared.
//  States IDLE, BUSY, RESP, DRAIN.
//  IDLE: ex_valid_i & ~flush_i & ~div_ready_i -> accept. Latch rd, op, neg_q, neg_r, magnitudes.
//   Magnitude: two's complement of an operand if signed op and bit31 set, else raw.
//   0x80000000 magnitude = 0x80000000.
//   Special (FAST_SPECIAL=1): rs2==0 or signed rs1=0x80000000/rs2=0xFFFFFFFF -> RESP next cycle.
//   Otherwise -> BUSY with div_start_o=1.
//  BUSY: start held; on div_ready_i=1 capture div_result_i, drop start -> RESP.
//   flush_i: start=0, annul=1 one cycle -> DRAIN, no writeback.
//  RESP: wb_valid_o=1 exactly one cycle -> IDLE; start stays 0.
//  DRAIN: wait div_ready_i=0 -> IDLE. Core must be idle before any new start.
//  stall_o = ex_valid_i & ~flush_i & (state!=RESP); drops in RESP so EX advances on that edge.
//  Sign rules: neg_q = signed & (rs1[31]^rs2[31]); neg_r = signed & rs1[31]; negate magnitude results.
//  Div by zero: quotient 0xFFFFFFFF, remainder = rs1 raw, all ops.
//  Signed overflow: quotient 0x80000000, remainder 0.
//  FAST_SPECIAL=0: core runs; core output ignored for special cases, above values substituted.
//  Latency accept->wb_valid_o: special 1 cycle; normal = core latency + 1.
//  flush_i in RESP: wb_valid_o suppressed that cycle.
//  flush_i in IDLE: nothing accepted.
//  Async reset mid-divide: immediate return to IDLE, outputs 0 (core reset by same rst_n).
// TESTING
//  DIV 20 / -6 -> wb_data 0xFFFFFFFD (-3); REM same -> 0x00000002; stall high throughout.
//  DIVU 0xFFFFFFFF / 0 -> 0xFFFFFFFF one cycle after accept, div_start_o never set (FAST_SPECIAL=1).
//  REM 0x80000000 / 0xFFFFFFFF -> 0; DIV same -> 0x80000000; both FAST_SPECIAL values.
//  flush_i 10 cycles into DIV -> one annul pulse, no wb_valid_o; next DIVU 7/2 -> 3, correct rd.
//  Back-to-back REMU 100/7 then DIV -7/2 -> 2 then 0xFFFFFFFD, one wb pulse each, no start overlap.
//  rst_n low mid-BUSY -> all outputs 0 at once; post-reset DIV 9/3 -> 3.

Source files
------------

// File: rtl/div_ctrl.sv
// RV32M divide controller sitting between EX and an iterative unsigned divider core.
// Owns operand sign handling, the div-by-zero and overflow results, and pipeline flushes.
module div_ctrl #(
    parameter int FAST_SPECIAL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic [1:0]  ex_op_i,
    input  logic [31:0] ex_rs1_i,
    input  logic [31:0] ex_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state;
    logic [4:0]  rd_q;
    logic [1:0]  op_q;
    logic        neg_q;
    logic        neg_r;
    logic        dz_q;
    logic        ovf_q;
    logic [31:0] rs1_q;
    logic [31:0] mag1_q;
    logic [31:0] mag2_q;
    logic [31:0] res_q;
    logic        start_q;
    logic        annul_q;

    logic        sgn_in;
    logic [31:0] mag1_in;
    logic [31:0] mag2_in;
    logic        dz_in;
    logic        ovf_in;
    logic        accept;
    logic        fast;

    // op[0] set means unsigned, op[1] set means remainder
    function automatic logic [31:0] final_result(
        input logic [1:0]  op,
        input logic [31:0] q,
        input logic [31:0] r,
        input logic        nq,
        input logic        nr,
        input logic        dz,
        input logic        ovf,
        input logic [31:0] dividend
    );
        logic [31:0] res;
        if (dz) begin
            res = op[1] ? dividend : 32'hFFFF_FFFF;
        end else if (ovf) begin
            res = op[1] ? 32'h0000_0000 : 32'h8000_0000;
        end else if (op[1]) begin
            res = nr ? (~r + 32'd1) : r;
        end else begin
            res = nq ? (~q + 32'd1) : q;
        end
        return res;
    endfunction

    always_comb begin
        sgn_in  = ~ex_op_i[0];
        mag1_in = (sgn_in && ex_rs1_i[31]) ? (~ex_rs1_i + 32'd1) : ex_rs1_i;
        mag2_in = (sgn_in && ex_rs2_i[31]) ? (~ex_rs2_i + 32'd1) : ex_rs2_i;
        dz_in   = (ex_rs2_i == '0);
        ovf_in  = sgn_in && (ex_rs1_i == 32'h8000_0000) && (ex_rs2_i == '1);
        accept  = (state == IDLE) && ex_valid_i && !flush_i && !div_ready_i;
        fast    = (FAST_SPECIAL != 0) && (dz_in || ovf_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_q    <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            rs1_q   <= '0;
            mag1_q  <= '0;
            mag2_q  <= '0;
            res_q   <= '0;
            start_q <= 1'b0;
            annul_q <= 1'b0;
        end else begin
            annul_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_q   <= ex_rd_i;
                        op_q   <= ex_op_i;
                        neg_q  <= sgn_in && (ex_rs1_i[31] ^ ex_rs2_i[31]);
                        neg_r  <= sgn_in && ex_rs1_i[31];
                        dz_q   <= dz_in;
                        ovf_q  <= ovf_in;
                        rs1_q  <= ex_rs1_i;
                        mag1_q <= mag1_in;
                        mag2_q <= mag2_in;
                        if (fast) begin
                            res_q <= final_result(ex_op_i, '0, '0, 1'b0, 1'b0,
                                                  dz_in, ovf_in, ex_rs1_i);
                            state <= RESP;
                        end else begin
                            start_q <= 1'b1;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // a flush wins over a same-cycle ready: the result is discarded
                    if (flush_i) begin
                        start_q <= 1'b0;
                        annul_q <= 1'b1;
                        state   <= DRAIN;
                    end else if (div_ready_i) begin
                        res_q   <= final_result(op_q, div_result_i[31:0], div_result_i[63:32],
                                                neg_q, neg_r, dz_q, ovf_q, rs1_q);
                        start_q <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (!div_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall_o      = ex_valid_i && !flush_i && (state != RESP);
    assign wb_valid_o   = (state == RESP) && !flush_i;
    assign wb_rd_o      = rd_q;
    assign wb_data_o    = res_q;
    assign div_op1_o    = mag1_q;
    assign div_op2_o    = mag2_q;
    assign div_start_o  = start_q;
    assign div_annul_o  = annul_q;
    assign div_signed_o = 1'b0;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: one instance per FAST_SPECIAL value, each with a behavioural divider core,
// a shared scoreboard of expected writebacks and a reference model built on plain SV arithmetic.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          sel;
    int          core_lat = 4;

    logic [1:0]       stall_v, wbv_v, start_v, annul_v, signed_v, ready_v;
    logic [1:0][4:0]  wbrd_v;
    logic [1:0][31:0] wbd_v, op1_v, op2_v;

    int tests = 0;
    int fails = 0;
    int wb_cnt[2];
    int annul_cnt[2];
    int start_rises[2];

    typedef struct packed {
        int          inst;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        logic        c_ready;
        logic [63:0] c_res;
        int          cnt;

        div_ctrl #(.FAST_SPECIAL(g == 0 ? 1 : 0)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .ex_valid_i   (ex_valid && (sel == g)),
            .ex_op_i      (op),
            .ex_rs1_i     (rs1),
            .ex_rs2_i     (rs2),
            .ex_rd_i      (rd),
            .flush_i      (flush && (sel == g)),
            .stall_o      (stall_v[g]),
            .wb_valid_o   (wbv_v[g]),
            .wb_rd_o      (wbrd_v[g]),
            .wb_data_o    (wbd_v[g]),
            .div_op1_o    (op1_v[g]),
            .div_op2_o    (op2_v[g]),
            .div_start_o  (start_v[g]),
            .div_annul_o  (annul_v[g]),
            .div_signed_o (signed_v[g]),
            .div_result_i (c_res),
            .div_ready_i  (c_ready)
        );

        assign ready_v[g] = c_ready;

        // divider core: ready rises core_lat cycles after start, held until start drops
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt     <= 0;
                c_ready <= 1'b0;
                c_res   <= '0;
            end else if (annul_v[g] || !start_v[g]) begin
                cnt     <= 0;
                c_ready <= 1'b0;
            end else if (!c_ready) begin
                cnt <= cnt + 1;
                if (cnt >= core_lat - 1) begin
                    c_ready <= 1'b1;
                    c_res   <= (op2_v[g] == 0) ? {op1_v[g], 32'hFFFF_FFFF}
                                               : {op1_v[g] % op2_v[g], op1_v[g] / op2_v[g]};
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        return o[1] ? a % b : a / b;
    endfunction

    function automatic logic [31:0] pick_a();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'(0);
            2:       return 32'($urandom_range(0, 200));
            3:       return -32'($urandom_range(1, 200));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_b();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(1, 20));
            3:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check_zero(input int i);
        check("rst_ctrl", {22'd0, stall_v[i], wbv_v[i], start_v[i], annul_v[i], signed_v[i],
                           wbrd_v[i], wbd_v[i]}, 64'd0);
        check("rst_ops", {op1_v[i], op2_v[i]}, 64'd0);
    endtask

    // called at a negedge; returns at the negedge after the instruction leaves EX
    task automatic issue(input int inst, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r);
        int   cyc;
        int   st0;
        int   exp_cyc;
        logic special;
        exp_t e;
        special = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        e.inst = inst;
        e.rd   = r;
        e.data = ref_result(o, a, b);
        sbq.push_back(e);
        st0 = start_rises[inst];
        sel = inst; op = o; rs1 = a; rs2 = b; rd = r; ex_valid = 1'b1;
        cyc = 0;
        #1;
        while (stall_v[inst]) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc > 500) begin
                tests++;
                fails++;
                $display("FAIL timeout: stall still high after %0d cycles, expected release", cyc);
                break;
            end
        end
        exp_cyc = (special && inst == 0) ? 1 : core_lat + 2;
        check("latency", 64'(cyc), 64'(exp_cyc));
        @(negedge clk);
        check("start_count", 64'(start_rises[inst] - st0), (special && inst == 0) ? 64'd0 : 64'd1);
        ex_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] prev_start;
        exp_t       e;
        prev_start = '0;
        forever begin
            @(negedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                if (wbv_v[i]) begin
                    wb_cnt[i]++;
                    if (sbq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL wb_unexpected: inst %0d rd %0d data 0x%0h, expected none",
                                 i, wbrd_v[i], wbd_v[i]);
                    end else begin
                        e = sbq.pop_front();
                        check("wb_data", 64'(wbd_v[i]), 64'(e.data));
                        check("wb_inst_rd", 64'(i * 32 + int'(wbrd_v[i])), 64'(e.inst * 32 + int'(e.rd)));
                    end
                end
                if (annul_v[i]) annul_cnt[i]++;
                if (start_v[i] && !prev_start[i]) begin
                    start_rises[i]++;
                    check("start_vs_ready", 64'(ready_v[i]), 64'd0);
                end
            end
            prev_start = start_v;
        end
    end

    initial begin
        int an0;
        int wb0;
        int st0;
        rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0;
        op = '0; rs1 = '0; rs2 = '0; rd = '0; sel = 0;
        repeat (2) @(negedge clk);
        #1;
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 2'b00, 32'd20, 32'hFFFF_FFFA, 5'd1);
        issue(0, 2'b10, 32'd20, 32'hFFFF_FFFA, 5'd2);
        issue(0, 2'b01, 32'hFFFF_FFFF, 32'd0, 5'd3);
        issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        issue(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
        issue(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        issue(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        issue(1, 2'b01, 32'hFFFF_FFFF, 32'd0, 5'd8);

        // flush ten cycles into a long divide
        core_lat = 20;
        an0 = annul_cnt[0];
        wb0 = wb_cnt[0];
        sel = 0; op = 2'b00; rs1 = 32'd1000; rs2 = 32'd7; rd = 5'd5; ex_valid = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("busy_stall", 64'(stall_v[0]), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_annul", 64'(annul_cnt[0] - an0), 64'd1);
        check("flush_no_wb", 64'(wb_cnt[0] - wb0), 64'd0);
        core_lat = 4;
        issue(0, 2'b01, 32'd7, 32'd2, 5'd9);

        wb0 = wb_cnt[0];
        issue(0, 2'b11, 32'd100, 32'd7, 5'd10);
        issue(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd11);
        check("b2b_wb_pulses", 64'(wb_cnt[0] - wb0), 64'd2);

        // flush while the instruction sits in IDLE: nothing may start
        st0 = start_rises[0];
        sel = 0; op = 2'b00; rs1 = 32'd5; rs2 = 32'd1; rd = 5'd12; ex_valid = 1'b1; flush = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_flush_stall", 64'(stall_v[0]), 64'd0);
        flush = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        check("idle_flush_start", 64'(start_rises[0] - st0), 64'd0);

        // flush landing in the response cycle suppresses the writeback
        wb0 = wb_cnt[0];
        sel = 0; op = 2'b01; rs1 = 32'd5; rs2 = 32'd0; rd = 5'd13; ex_valid = 1'b1;
        @(negedge clk);
        flush = 1'b1;
        #3;
        check("resp_flush_wbv", 64'(wbv_v[0]), 64'd0);
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        check("resp_flush_no_wb", 64'(wb_cnt[0] - wb0), 64'd0);

        // asynchronous reset in the middle of a divide
        core_lat = 20;
        sel = 0; op = 2'b00; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd14; ex_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_start", 64'(start_v[0]), 64'd1);
        rst_n = 1'b0; ex_valid = 1'b0;
        #1;
        check_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        core_lat = 4;
        issue(0, 2'b00, 32'd9, 32'd3, 5'd15);

        for (int n = 0; n < 160; n++) begin
            core_lat = $urandom_range(1, 6);
            issue((n % 4 == 3) ? 1 : 0, 2'($urandom_range(0, 3)), pick_a(), pick_b(),
                  5'($urandom_range(1, 31)));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
